// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks every architectural register through one
// register-file read port and streams each value on a valid/ready channel.
// Optional build macro REGDUMP_CHECKSUM_EN appends an XOR checksum beat.
module regfile_dump_reader #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [REG_ADDR_WIDTH-1:0] read_address_o,
   input  logic [XLEN-1:0]           read_data_i,
   output logic                      dump_valid_o,
   input  logic                      dump_ready_i,
   output logic [XLEN-1:0]           dump_data_o,
   output logic [REG_ADDR_WIDTH-1:0] dump_index_o,
   output logic                      dump_last_o,
   output logic                      dump_csum_o
);

   localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = '1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_SEND  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
`ifdef REGDUMP_CHECKSUM_EN
   localparam logic [2:0] S_CSUM  = 3'd4;
`endif

   logic [2:0]                r_state;
   logic [2:0]                w_next_state;
   logic [REG_ADDR_WIDTH-1:0] r_index;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_dump_valid;
   logic [XLEN-1:0]           r_dump_data;
   logic [REG_ADDR_WIDTH-1:0] r_dump_index;
   logic                      r_dump_last;
   logic                      w_handshake;
   logic                      w_at_last;
`ifdef REGDUMP_CHECKSUM_EN
   logic [XLEN-1:0]           r_csum;
   logic                      r_dump_csum;
`endif

   assign w_handshake = r_dump_valid & dump_ready_i;
   assign w_at_last   = (r_index == LAST_IDX);

   // The index counter doubles as the read address; it sits at 0 outside a dump.
   assign read_address_o = r_index;
   assign busy_o         = r_busy;
   assign done_o         = r_done;
   assign dump_valid_o   = r_dump_valid;
   assign dump_data_o    = r_dump_data;
   assign dump_index_o   = r_dump_index;
   assign dump_last_o    = r_dump_last;
`ifdef REGDUMP_CHECKSUM_EN
   assign dump_csum_o    = r_dump_csum;
`else
   assign dump_csum_o    = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_next_state = S_FETCH;
            end
         end
         S_FETCH: begin
            w_next_state = S_SEND;
         end
         S_SEND: begin
            if (w_handshake) begin
               if (w_at_last) begin
`ifdef REGDUMP_CHECKSUM_EN
                  w_next_state = S_CSUM;
`else
                  w_next_state = S_DONE;
`endif
               end else begin
                  w_next_state = S_FETCH;
               end
            end
         end
`ifdef REGDUMP_CHECKSUM_EN
         S_CSUM: begin
            if (w_handshake) begin
               w_next_state = S_DONE;
            end
         end
`endif
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Datapath and registered outputs, advanced by the current state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_index      <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_dump_valid <= 1'b0;
         r_dump_data  <= '0;
         r_dump_index <= '0;
         r_dump_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
         r_csum       <= '0;
         r_dump_csum  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_index <= '0;
                  r_busy  <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                  r_csum  <= '0;
`endif
               end
            end
            S_FETCH: begin
               r_dump_data  <= read_data_i;
               r_dump_index <= r_index;
               r_dump_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
               r_dump_last  <= 1'b0;
               r_csum       <= r_csum ^ read_data_i;
`else
               r_dump_last  <= w_at_last;
`endif
            end
            S_SEND: begin
               if (w_handshake) begin
                  if (w_at_last) begin
                     // Counter is parked at 0 instead of wrapping past the last address.
                     r_index <= '0;
`ifdef REGDUMP_CHECKSUM_EN
                     r_dump_valid <= 1'b1;
                     r_dump_data  <= r_csum;
                     r_dump_index <= '0;
                     r_dump_last  <= 1'b1;
                     r_dump_csum  <= 1'b1;
`else
                     r_dump_valid <= 1'b0;
                     r_busy       <= 1'b0;
                     r_done       <= 1'b1;
`endif
                  end else begin
                     r_dump_valid <= 1'b0;
                     r_index      <= REG_ADDR_WIDTH'(r_index + 1'b1);
                  end
               end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
               if (w_handshake) begin
                  r_dump_valid <= 1'b0;
                  r_dump_csum  <= 1'b0;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a behavioural register file
// feeds the read port, and every streamed beat is compared with the value the
// register file holds for that index (x0 always 0) plus an XOR checksum beat
// when REGDUMP_CHECKSUM_EN is defined.
module tb_regfile_dump_reader;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned NREG = 32;
`ifdef REGDUMP_CHECKSUM_EN
   localparam int NBEATS = 33;
`else
   localparam int NBEATS = 32;
`endif

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            start_i;
   logic            busy_o;
   logic            done_o;
   logic [AW-1:0]   read_address_o;
   logic [XLEN-1:0] read_data_i;
   logic            dump_valid_o;
   logic            dump_ready_i;
   logic [XLEN-1:0] dump_data_o;
   logic [AW-1:0]   dump_index_o;
   logic            dump_last_o;
   logic            dump_csum_o;

   logic [XLEN-1:0] rf [NREG];

   int n_cmp = 0;
   int n_err = 0;

   regfile_dump_reader #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .start_i        (start_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .read_address_o (read_address_o),
      .read_data_i    (read_data_i),
      .dump_valid_o   (dump_valid_o),
      .dump_ready_i   (dump_ready_i),
      .dump_data_o    (dump_data_o),
      .dump_index_o   (dump_index_o),
      .dump_last_o    (dump_last_o),
      .dump_csum_o    (dump_csum_o)
   );

   // Register file read port: combinational, x0 hardwired to zero.
   assign read_data_i = (read_address_o == '0) ? '0 : rf[read_address_o];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 64'(dump_valid_o), 64'd0);
      chk({tag, "_busy"},  64'(busy_o),       64'd0);
      chk({tag, "_done"},  64'(done_o),       64'd0);
      chk({tag, "_data"},  64'(dump_data_o),  64'd0);
      chk({tag, "_index"}, 64'(dump_index_o), 64'd0);
      chk({tag, "_last"},  64'(dump_last_o),  64'd0);
      chk({tag, "_csum"},  64'(dump_csum_o),  64'd0);
      chk({tag, "_raddr"}, 64'(read_address_o), 64'd0);
   endtask

   // One dump from start pulse to done; inputs driven and outputs sampled on negedge.
   task automatic run_dump(input int ready_pct, input int stall_beat, input int restart_beat,
                           input int write_beat, input bit full_rate, input int abort_beat);
      int              b = 0;
      int              cyc = 0;
      int              stall_cnt = 0;
      int              dones = 0;
      int              first_lat = -1;
      bit              pulsed = 0;
      bit              wrote = 0;
      logic [XLEN-1:0] xacc = '0;
      logic [XLEN-1:0] ed;
      logic            pvalid = 1'b0;
      logic            paccepted = 1'b0;
      logic [XLEN-1:0] pdata = '0;
      logic [AW-1:0]   pidx = '0;
      logic            plast = 1'b0;

      @(negedge clk);
      dump_ready_i = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      cyc = 1;
      chk("busy_after_start", 64'(busy_o), 64'd1);
      chk("valid_after_start", 64'(dump_valid_o), 64'd0);

      while (b < NBEATS && cyc < 3000) begin
         start_i = 1'b0;
         if (dump_valid_o && first_lat < 0) first_lat = cyc;
         if (done_o) dones++;
         if (dump_valid_o && pvalid && !paccepted) begin
            chk("hold_data",  64'(dump_data_o),  64'(pdata));
            chk("hold_index", 64'(dump_index_o), 64'(pidx));
            chk("hold_last",  64'(dump_last_o),  64'(plast));
         end
         if (dump_valid_o) begin
            if (b == abort_beat) begin
               rst_ni = 1'b0;
               dump_ready_i = 1'b0;
               @(negedge clk);
               rst_ni = 1'b1;
               chk_idle("abort");
               @(negedge clk);
               chk("abort_stays_idle", 64'(busy_o | dump_valid_o), 64'd0);
               return;
            end
            if (b == restart_beat && !pulsed) begin
               start_i = 1'b1;
               pulsed = 1;
            end
            if (b == write_beat && !wrote) begin
               rf[20] = 32'hDEAD_BEEF;
               wrote = 1;
            end
            if (b == stall_beat && stall_cnt < 5) begin
               dump_ready_i = 1'b0;
               stall_cnt++;
            end else begin
               dump_ready_i = (int'($urandom_range(0, 99)) < ready_pct);
            end
            if (dump_ready_i) begin
               chk("beat_busy", 64'(busy_o), 64'd1);
               if (b < int'(NREG)) begin
                  ed = (b == 0) ? '0 : rf[b];
                  xacc ^= ed;
                  chk("beat_index", 64'(dump_index_o), 64'(b));
                  chk("beat_data",  64'(dump_data_o),  64'(ed));
                  chk("beat_last",  64'(dump_last_o),  64'((b == int'(NREG) - 1) && (NBEATS == int'(NREG))));
                  chk("beat_csum",  64'(dump_csum_o),  64'd0);
                  if (b == 20 && write_beat >= 0)
                     chk("beat20_written", 64'(dump_data_o), 64'h0000_0000_DEAD_BEEF);
               end else begin
                  chk("csum_index", 64'(dump_index_o), 64'd0);
                  chk("csum_data",  64'(dump_data_o),  64'(xacc));
                  chk("csum_last",  64'(dump_last_o),  64'd1);
                  chk("csum_flag",  64'(dump_csum_o),  64'd1);
               end
               b++;
            end
         end else begin
            dump_ready_i = ($urandom_range(0, 1) == 1);
         end
         pvalid    = dump_valid_o;
         paccepted = dump_valid_o & dump_ready_i;
         pdata     = dump_data_o;
         pidx      = dump_index_o;
         plast     = dump_last_o;
         @(negedge clk);
         cyc++;
      end
      start_i = 1'b0;
      dump_ready_i = 1'b0;

      chk("beats_accepted", 64'(b), 64'(NBEATS));
      chk("first_valid_latency", 64'(first_lat), 64'd2);
      chk("no_early_done", 64'(dones), 64'd0);
      chk("done_pulse", 64'(done_o), 64'd1);
      chk("done_busy", 64'(busy_o), 64'd0);
      chk("done_valid", 64'(dump_valid_o), 64'd0);
      if (full_rate) chk("dump_cycles", 64'(cyc), 64'(2 * NREG + 1 + (NBEATS - NREG)));
      @(negedge clk);
      chk("done_single", 64'(done_o), 64'd0);
      chk("idle_busy", 64'(busy_o), 64'd0);
      chk("idle_raddr", 64'(read_address_o), 64'd0);
      @(negedge clk);
      chk("start_not_queued", 64'(busy_o | dump_valid_o | done_o), 64'd0);
   endtask

   initial begin
      rst_ni = 1'b0;
      start_i = 1'b0;
      dump_ready_i = 1'b0;
      rf[0] = 32'hFFFF_FFFF;
      for (int k = 1; k < int'(NREG); k++) rf[k] = 32'h1000_0000 + 32'(k);

      // Reset state.
      repeat (3) @(negedge clk);
      chk_idle("reset");
      rst_ni = 1'b1;
      @(negedge clk);
      chk_idle("post_reset");

      // Full-rate dump of the preload pattern.
      run_dump(100, -1, -1, -1, 1'b1, -1);
      // Backpressure on beat 7 for five cycles.
      run_dump(100, 7, -1, -1, 1'b0, -1);
      // Spurious start during beat 12.
      run_dump(100, -1, 12, -1, 1'b0, -1);
      // Reset while beat 10 is valid, then a clean dump from index 0.
      run_dump(100, -1, -1, -1, 1'b0, 10);
      run_dump(100, -1, -1, -1, 1'b1, -1);
      // Register 20 rewritten during beat 5.
      run_dump(100, -1, -1, 5, 1'b0, -1);

      // Random contents and random backpressure.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < int'(NREG); k++) rf[k] = $urandom;
         run_dump(60, int'($urandom_range(0, NBEATS - 1)), -1, -1, 1'b0, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
